// File: rtl/audio_stream_engine.sv
// audio_stream_engine
//   Multi-channel audio sample loop. Once per sample period it walks every
//   channel in turn. For each channel it reads the playback word from the
//   interleaved RAM ring and shifts it out to the SPI DAC. It then captures
//   one SPI ADC conversion and writes that capture back over the same word.
//
// Ports
//   system_clock  sole clock; also the SPI SCLK of both converters
//   reset_n       asynchronous active-low reset
//   en            run enable, sampled on each frame tick
//   overrun_clr   clears the sticky overrun flag
//   mem_*         single shared RAM port (word addressed, byte write enables)
//   dac_cs/mosi   SPI DAC chip select (active low) and data
//   adc_cs/mosi   SPI ADC chip select (active low) and channel-address data
//   adc_miso      SPI ADC conversion data
//   frame_idx     current frame in the ring
//   busy_half     ring half currently in use
//   half_irq      one-cycle pulse when frame_idx enters either half
//   overrun       sticky: a frame tick arrived while a frame was in progress
//
// state  | meaning
// IDLE   | waiting for a frame tick with en=1
// RD     | RAM read strobe for the current channel
// WAIT   | RAM read latency; read data captured on the last cycle
// DAC    | 16 cycles shifting the DAC frame, dac_cs low
// ADC    | 16 cycles shifting the channel address and capturing adc_miso
// WR     | RAM write of the captured sample; advance channel or frame
module audio_stream_engine #(
    parameter int                CHANNELS          = 1,
    parameter int                CLOCKS_PER_SAMPLE = 600,
    parameter int                ADDR_W            = 15,
    parameter logic [ADDR_W-1:0] BUF_BASE          = ADDR_W'('h6000),
    parameter int                BUF_FRAMES        = 8192,
    parameter int                RD_LAT            = 2,
    parameter int                DAC_BITS          = 10,
    parameter int                ADC_BITS          = 8,
    parameter int                ADC_MSB           = 11
) (
    input  logic                          system_clock,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic                          overrun_clr,
    output logic                          mem_en,
    output logic [1:0]                    mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [15:0]                   mem_wdata,
    input  logic [15:0]                   mem_rdata,
    output logic                          dac_cs,
    output logic                          dac_mosi,
    output logic                          adc_cs,
    output logic                          adc_mosi,
    input  logic                          adc_miso,
    output logic [$clog2(BUF_FRAMES)-1:0] frame_idx,
    output logic                          busy_half,
    output logic                          half_irq,
    output logic                          overrun
);

    localparam int FW    = $clog2(BUF_FRAMES);
    localparam int SMP_W = $clog2(CLOCKS_PER_SAMPLE);
    localparam int TMR_W = $clog2(RD_LAT + 16);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_DAC, S_ADC, S_WR} state_t;

    state_t              state_q;
    logic [SMP_W-1:0]    smp_cnt_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [1:0]          ch_q;
    logic [FW-1:0]       frame_q;
    logic [15:0]         dac_sr_q;
    logic [15:0]         cmd_sr_q;
    logic [14:0]         adc_sr_q;
    logic                mem_en_q;
    logic [1:0]          mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic                dac_cs_q;
    logic                dac_mosi_q;
    logic                adc_cs_q;
    logic                adc_mosi_q;
    logic                busy_half_q;
    logic                half_irq_q;
    logic                overrun_q;

    logic                tick;
    logic [1:0]          ch_sel_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [15:0]         dac_word_d;
    logic [15:0]         adc_cmd_d;
    logic [15:0]         adc_full_d;
    logic [15:0]         wdata_d;
    logic [FW-1:0]       frame_nxt_d;
    logic                unused_bits;

    assign tick = (smp_cnt_q == SMP_W'(CLOCKS_PER_SAMPLE - 1));

    // Channel whose RD is issued next: channel 0 from IDLE, ch+1 after a WR.
    assign ch_sel_d = (state_q == S_WR) ? ch_q + 2'd1 : 2'd0;
    assign addr_d   = BUF_BASE + ADDR_W'(frame_q) * ADDR_W'(CHANNELS) + ADDR_W'(ch_sel_d);

    assign adc_cmd_d   = {2'b00, 1'b0, ch_q, 11'b0};
    assign adc_full_d  = {adc_sr_q, adc_miso};
    assign frame_nxt_d = (frame_q == FW'(BUF_FRAMES - 1)) ? '0 : frame_q + FW'(1);

    always_comb begin
        dac_word_d                 = '0;
        dac_word_d[15:14]          = ch_q;
        dac_word_d[11 -: DAC_BITS] = mem_rdata[15 -: DAC_BITS];
        wdata_d                    = '0;
        wdata_d[15 -: ADC_BITS]    = adc_full_d[ADC_MSB -: ADC_BITS];
    end

    // Sample bits that never reach the DAC or the stored field.
    assign unused_bits = ^{mem_rdata, adc_full_d};

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            smp_cnt_q   <= '0;
            tmr_q       <= '0;
            ch_q        <= '0;
            frame_q     <= '0;
            dac_sr_q    <= '0;
            cmd_sr_q    <= '0;
            adc_sr_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dac_cs_q    <= 1'b1;
            dac_mosi_q  <= 1'b0;
            adc_cs_q    <= 1'b1;
            adc_mosi_q  <= 1'b0;
            busy_half_q <= 1'b0;
            half_irq_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            smp_cnt_q  <= tick ? '0 : smp_cnt_q + SMP_W'(1);
            half_irq_q <= 1'b0;

            // A tick while busy is dropped; a new overrun beats a clear.
            if (tick && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (tick && en) begin
                        state_q    <= S_RD;
                        ch_q       <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_d;
                    end
                end
                S_RD: begin
                    mem_en_q <= 1'b0;
                    tmr_q    <= TMR_W'(RD_LAT - 1);
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (tmr_q == '0) begin
                        state_q    <= S_DAC;
                        dac_cs_q   <= 1'b0;
                        dac_mosi_q <= dac_word_d[15];
                        dac_sr_q   <= {dac_word_d[14:0], 1'b0};
                        tmr_q      <= TMR_W'(15);
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                S_DAC: begin
                    if (tmr_q == '0) begin
                        state_q    <= S_ADC;
                        dac_cs_q   <= 1'b1;
                        dac_mosi_q <= 1'b0;
                        adc_cs_q   <= 1'b0;
                        adc_mosi_q <= adc_cmd_d[15];
                        cmd_sr_q   <= {adc_cmd_d[14:0], 1'b0};
                        tmr_q      <= TMR_W'(15);
                    end else begin
                        dac_mosi_q <= dac_sr_q[15];
                        dac_sr_q   <= {dac_sr_q[14:0], 1'b0};
                        tmr_q      <= tmr_q - TMR_W'(1);
                    end
                end
                S_ADC: begin
                    adc_sr_q <= adc_full_d[14:0];
                    if (tmr_q == '0) begin
                        state_q     <= S_WR;
                        adc_cs_q    <= 1'b1;
                        adc_mosi_q  <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 2'b11;
                        mem_wdata_q <= wdata_d;
                    end else begin
                        adc_mosi_q <= cmd_sr_q[15];
                        cmd_sr_q   <= {cmd_sr_q[14:0], 1'b0};
                        tmr_q      <= tmr_q - TMR_W'(1);
                    end
                end
                S_WR: begin
                    mem_we_q <= 2'b00;
                    if (ch_q == 2'(CHANNELS - 1)) begin
                        state_q     <= S_IDLE;
                        mem_en_q    <= 1'b0;
                        frame_q     <= frame_nxt_d;
                        busy_half_q <= (frame_nxt_d >= FW'(BUF_FRAMES / 2));
                        half_irq_q  <= (frame_nxt_d == FW'(BUF_FRAMES / 2)) || (frame_nxt_d == '0);
                    end else begin
                        state_q    <= S_RD;
                        ch_q       <= ch_sel_d;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign dac_cs    = dac_cs_q;
    assign dac_mosi  = dac_mosi_q;
    assign adc_cs    = adc_cs_q;
    assign adc_mosi  = adc_mosi_q;
    assign frame_idx = frame_q;
    assign busy_half = busy_half_q;
    assign half_irq  = half_irq_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_audio_stream_engine.sv
// Directed bench for audio_stream_engine. Four instances cover:
//   0: defaults (single channel, 600-cycle frames)
//   1: two channels, 100-cycle frames
//   2: single channel, 4-frame ring, 100-cycle frames
//   3: two channels, 50-cycle frames (deliberately too short, forces overrun)
module tb_audio_stream_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  en = 4'b0000;
    logic [3:0]  clr = 4'b0000;
    logic [15:0] rdata = 16'hABCD;
    logic [15:0] adc_pat = 16'h0F50;
    logic [3:0]  adc_miso = 4'b0000;
    int unsigned miso_idx [4];

    wire [3:0]        mem_en, dac_cs, dac_mosi, adc_cs, adc_mosi, busy_half, half_irq, overrun;
    wire [3:0][1:0]   mem_we;
    wire [3:0][14:0]  mem_addr;
    wire [3:0][15:0]  mem_wdata;
    wire [12:0]       fi_a, fi_b, fi_d;
    wire [1:0]        fi_c;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // ADC model: presents the next pattern bit mid-cycle while adc_cs is low.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (adc_cs[k]) begin
                miso_idx[k] = 0;
                adc_miso[k] = adc_pat[15];
            end else begin
                if (miso_idx[k] < 16) adc_miso[k] = adc_pat[15 - miso_idx[k]];
                miso_idx[k]++;
            end
        end
    end

    audio_stream_engine u_a (
        .system_clock(clk), .reset_n(reset_n), .en(en[0]), .overrun_clr(clr[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(rdata), .dac_cs(dac_cs[0]), .dac_mosi(dac_mosi[0]), .adc_cs(adc_cs[0]),
        .adc_mosi(adc_mosi[0]), .adc_miso(adc_miso[0]), .frame_idx(fi_a),
        .busy_half(busy_half[0]), .half_irq(half_irq[0]), .overrun(overrun[0]));

    audio_stream_engine #(.CHANNELS(2), .CLOCKS_PER_SAMPLE(100)) u_b (
        .system_clock(clk), .reset_n(reset_n), .en(en[1]), .overrun_clr(clr[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(rdata), .dac_cs(dac_cs[1]), .dac_mosi(dac_mosi[1]), .adc_cs(adc_cs[1]),
        .adc_mosi(adc_mosi[1]), .adc_miso(adc_miso[1]), .frame_idx(fi_b),
        .busy_half(busy_half[1]), .half_irq(half_irq[1]), .overrun(overrun[1]));

    audio_stream_engine #(.BUF_FRAMES(4), .CLOCKS_PER_SAMPLE(100)) u_c (
        .system_clock(clk), .reset_n(reset_n), .en(en[2]), .overrun_clr(clr[2]),
        .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
        .mem_rdata(rdata), .dac_cs(dac_cs[2]), .dac_mosi(dac_mosi[2]), .adc_cs(adc_cs[2]),
        .adc_mosi(adc_mosi[2]), .adc_miso(adc_miso[2]), .frame_idx(fi_c),
        .busy_half(busy_half[2]), .half_irq(half_irq[2]), .overrun(overrun[2]));

    audio_stream_engine #(.CHANNELS(2), .CLOCKS_PER_SAMPLE(50)) u_d (
        .system_clock(clk), .reset_n(reset_n), .en(en[3]), .overrun_clr(clr[3]),
        .mem_en(mem_en[3]), .mem_we(mem_we[3]), .mem_addr(mem_addr[3]), .mem_wdata(mem_wdata[3]),
        .mem_rdata(rdata), .dac_cs(dac_cs[3]), .dac_mosi(dac_mosi[3]), .adc_cs(adc_cs[3]),
        .adc_mosi(adc_mosi[3]), .adc_miso(adc_miso[3]), .frame_idx(fi_d),
        .busy_half(busy_half[3]), .half_irq(half_irq[3]), .overrun(overrun[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a RAM read strobe on instance k; cyc=-1 on timeout.
    task automatic wait_rd(input int k, input int budget, input bit any,
                           input logic [14:0] addr, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (mem_en[k] && mem_we[k] == 2'b00 && (any || mem_addr[k] == addr)) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Called at the negedge of an RD cycle; follows the channel up to its WR.
    task automatic run_channel(input int k, input int drop_at,
                               output logic [14:0] ra, output logic [15:0] dfr,
                               output logic [15:0] acmd, output logic [14:0] wa,
                               output logic [15:0] wd, output int wr_off,
                               output int dlow, output int alow, output int stray);
        ra = mem_addr[k]; dfr = '0; acmd = '0; wa = '0; wd = '0;
        wr_off = -1; dlow = 0; alow = 0; stray = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == drop_at) en[k] = 1'b0;
            if (!dac_cs[k]) begin dfr = {dfr[14:0], dac_mosi[k]}; dlow++; end
            if (!adc_cs[k]) begin acmd = {acmd[14:0], adc_mosi[k]}; alow++; end
            if (mem_en[k] && mem_we[k] == 2'b11) begin
                wr_off = c; wa = mem_addr[k]; wd = mem_wdata[k];
                break;
            end
            if (mem_en[k] || mem_we[k] != 2'b00) stray++;
        end
    endtask

    initial begin
        logic [14:0] ra, wa;
        logic [15:0] dfr, acmd, wd;
        int wr_off, dlow, alow, stray, cyc;
        int trans [8];
        int ntr, irq2, irq0, irqx, bh_err;
        logic [1:0] prev;

        // ---- reset values ----
        #12;
        chk("rst_dac_cs", dac_cs, 4'b1111);
        chk("rst_adc_cs", adc_cs, 4'b1111);
        chk("rst_mosi", {dac_mosi, adc_mosi}, 8'h00);
        chk("rst_mem_en", mem_en, 4'b0000);
        chk("rst_mem_we", mem_we[0], 2'b00);
        chk("rst_mem_addr", mem_addr[0], 15'h0000);
        chk("rst_mem_wdata", mem_wdata[0], 16'h0000);
        chk("rst_frame", fi_a, 13'd0);
        chk("rst_flags", {busy_half[0], half_irq[0], overrun[0]}, 3'b000);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- instance 0: single channel, defaults ----
        en[0] = 1'b1;
        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        chk("a_rd0_addr", mem_addr[0], 15'h6000);
        chk("a_rd0_frame", fi_a, 13'd0);
        run_channel(0, 0, ra, dfr, acmd, wa, wd, wr_off, dlow, alow, stray);
        chk("a_dac_frame", dfr, 16'h0ABC);
        chk("a_dac_len", dlow, 16);
        chk("a_adc_cmd", acmd, 16'h0000);
        chk("a_adc_len", alow, 16);
        chk("a_wr_offset", wr_off, 35);
        chk("a_wr_addr", wa, 15'h6000);
        chk("a_wr_data", wd, 16'hF500);
        chk("a_stray_mem", stray, 0);
        @(negedge clk);
        chk("a_frame_after", fi_a, 13'd1);
        chk("a_mem_idle", {mem_en[0], mem_we[0]}, 3'b000);
        chk("a_cs_idle", {dac_cs[0], adc_cs[0]}, 2'b11);

        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        chk("a_rd1_addr", mem_addr[0], 15'h6001);
        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        chk("a_rd2_addr", mem_addr[0], 15'h6002);
        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        chk("a_rd3_addr", mem_addr[0], 15'h6003);
        run_channel(0, 6, ra, dfr, acmd, wa, wd, wr_off, dlow, alow, stray);
        chk("a_f3_wr_offset", wr_off, 35);
        chk("a_f3_wr_addr", wa, 15'h6003);
        wait_rd(0, 1300, 1'b1, 15'h0, cyc);
        chk("a_no_rd_after_en_drop", cyc, -1);
        chk("a_frame_held", fi_a, 13'd4);
        en[0] = 1'b1;
        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        chk("a_resume_found", (cyc > 0), 1'b1);
        chk("a_resume_addr", mem_addr[0], 15'h6004);

        // ---- instance 1: two channels ----
        en[1] = 1'b1;
        wait_rd(1, 200, 1'b1, 15'h0, cyc);
        chk("b_rd_ch0_addr", mem_addr[1], 15'h6000);
        run_channel(1, 0, ra, dfr, acmd, wa, wd, wr_off, dlow, alow, stray);
        chk("b_ch0_dac", dfr, 16'h0ABC);
        chk("b_ch0_wr_addr", wa, 15'h6000);
        wait_rd(1, 1, 1'b0, 15'h6001, cyc);
        chk("b_ch1_rd_gap", cyc, 1);
        run_channel(1, 0, ra, dfr, acmd, wa, wd, wr_off, dlow, alow, stray);
        chk("b_ch1_dac", dfr, 16'h4ABC);
        chk("b_ch1_adc_cmd", acmd, 16'h0800);
        chk("b_ch1_wr_addr", wa, 15'h6001);
        chk("b_ch1_wr_data", wd, 16'hF500);
        chk("b_ch1_stray_mem", stray, 0);
        wait_rd(1, 200, 1'b1, 15'h0, cyc);
        chk("b_frame1_addr", mem_addr[1], 15'h6002);
        en[1] = 1'b0;

        // ---- instance 2: 4-frame ring, half boundaries ----
        prev = fi_c; ntr = 0; irq2 = 0; irq0 = 0; irqx = 0; bh_err = 0;
        en[2] = 1'b1;
        for (int c = 0; c < 900; c++) begin
            @(negedge clk);
            if (fi_c != prev) begin
                if (ntr < 8) trans[ntr] = int'(fi_c);
                ntr++;
                prev = fi_c;
            end
            if (half_irq[2]) begin
                if (fi_c == 2'd2) irq2++;
                else if (fi_c == 2'd0) irq0++;
                else irqx++;
            end
            if (busy_half[2] !== (fi_c >= 2'd2)) bh_err++;
            if (ntr == 4 && mem_en[2] && mem_we[2] == 2'b00) en[2] = 1'b0;
        end
        chk("c_transitions", ntr, 5);
        chk("c_seq", {trans[0][3:0], trans[1][3:0], trans[2][3:0], trans[3][3:0], trans[4][3:0]}, 20'h12301);
        chk("c_irq_at_2", irq2, 1);
        chk("c_irq_at_0", irq0, 1);
        chk("c_irq_other", irqx, 0);
        chk("c_busy_half", bh_err, 0);

        // ---- instance 3: overrun ----
        en[3] = 1'b1;
        wait_rd(3, 100, 1'b1, 15'h0, cyc);
        chk("d_rd0_addr", mem_addr[3], 15'h6000);
        chk("d_overrun_pre", overrun[3], 1'b0);
        wait_rd(3, 150, 1'b0, 15'h6002, cyc);
        chk("d_dropped_tick_gap", cyc, 100);
        chk("d_overrun_set", overrun[3], 1'b1);
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
        chk("d_overrun_cleared", overrun[3], 1'b0);
        repeat (48) @(negedge clk);
        chk("d_overrun_pre_tick", overrun[3], 1'b0);
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
        chk("d_set_beats_clear", overrun[3], 1'b1);
        en[3] = 1'b0;

        // ---- reset mid-transfer on instance 0 ----
        wait_rd(0, 700, 1'b1, 15'h0, cyc);
        repeat (5) @(negedge clk);
        chk("r_in_dac_phase", dac_cs[0], 1'b0);
        reset_n = 1'b0;
        #1;
        chk("r_dac_cs", dac_cs[0], 1'b1);
        chk("r_adc_cs", adc_cs[0], 1'b1);
        chk("r_mem_en", mem_en[0], 1'b0);
        chk("r_frame", fi_a, 13'd0);
        chk("r_irq_overrun", {half_irq[0], overrun[3]}, 2'b00);
        repeat (5) @(negedge clk);
        chk("r_hold", {dac_cs[0], adc_cs[0], mem_en[0]}, 3'b110);
        reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
